// File: rtl/rf_write_sched_if.sv
// Request, register-file write and hazard-query signals of rf_write_sched.
// slave is the scheduler side; master is the requester / register-file side.
interface rf_write_sched_if;
    logic        req0_valid;
    logic [2:0]  req0_addr;
    logic [14:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [2:0]  req1_addr;
    logic [14:0] req1_data;
    logic        req1_ready;
    logic [2:0]  rf_wa;
    logic [14:0] rf_wd;
    logic        rf_we;
    logic [2:0]  rd1_addr;
    logic [2:0]  rd2_addr;
    logic        hazard1;
    logic        hazard2;
    logic        drop_err;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  rd1_addr, rd2_addr,
        output req0_ready, req1_ready,
        output rf_wa, rf_wd, rf_we,
        output hazard1, hazard2, drop_err
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output rd1_addr, rd2_addr,
        input  req0_ready, req1_ready,
        input  rf_wa, rf_wd, rf_we,
        input  hazard1, hazard2, drop_err
    );
endinterface

// File: rtl/rf_write_sched.sv
// Two-requester register-file write scheduler. Each requester feeds its own
// DEPTH-entry FIFO; one head per cycle is granted round-robin and registered
// onto the register-file write port. Writes to address 7 are accepted but
// discarded (sticky drop_err). hazard1/2 flag reads that hit a pending write.
module rf_write_sched #(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    rf_write_sched_if.slave bus
);
    localparam int DATA_W = 15;
    localparam int ADDR_W = 3;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [ADDR_W-1:0] DROP_ADDR = 3'd7;

    logic [1:0]        req_valid;
    logic [ADDR_W-1:0] req_addr [2];
    logic [DATA_W-1:0] req_data [2];
    logic [1:0]        req_ready;

    logic [ADDR_W-1:0] mem_addr [2][DEPTH];
    logic [DATA_W-1:0] mem_data [2][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [2];
    logic [PTR_W-1:0]  rd_ptr [2];
    logic [CNT_W-1:0]  cnt [2];

    logic [1:0] full;
    logic [1:0] empty;
    logic [1:0] accept;
    logic [1:0] push;
    logic [1:0] pop;

    // last_grant = 1 means requester 1 was served most recently
    logic last_grant;
    logic grant_vld;
    logic grant_sel;

    logic              we_p1;
    logic [ADDR_W-1:0] wa_p1;
    logic [DATA_W-1:0] wd_p1;
    logic              drop_err_q;
    logic              hz1;
    logic              hz2;

    assign req_valid   = {bus.req1_valid, bus.req0_valid};
    assign req_addr[0] = bus.req0_addr;
    assign req_addr[1] = bus.req1_addr;
    assign req_data[0] = bus.req0_data;
    assign req_data[1] = bus.req1_data;

    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];
    assign bus.rf_we      = we_p1;
    assign bus.rf_wa      = wa_p1;
    assign bus.rf_wd      = wd_p1;
    assign bus.drop_err   = drop_err_q;
    assign bus.hazard1    = hz1;
    assign bus.hazard2    = hz2;

    // FIFO status and handshake: ready is purely "not full" (no bypass) and low during reset
    always_comb begin
        full      = '0;
        empty     = '0;
        req_ready = '0;
        accept    = '0;
        push      = '0;
        for (int n = 0; n < 2; n++) begin
            full[n]      = (cnt[n] == CNT_W'(DEPTH));
            empty[n]     = (cnt[n] == '0);
            req_ready[n] = !full[n] && !rst;
            accept[n]    = req_valid[n] && req_ready[n];
            push[n]      = accept[n] && (req_addr[n] != DROP_ADDR);
        end
    end

    // Round-robin grant: a lone non-empty FIFO wins; on a tie the one not served last wins
    always_comb begin
        grant_vld = !empty[0] || !empty[1];
        grant_sel = 1'b0;
        if (!empty[0] && (empty[1] || last_grant)) begin
            grant_sel = 1'b0;
        end else if (!empty[1]) begin
            grant_sel = 1'b1;
        end
        pop = '0;
        if (grant_vld) begin
            pop[grant_sel] = 1'b1;
        end
    end

    // FIFO pointers and occupancy; pointers wrap modulo DEPTH
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (rst) begin
                wr_ptr[n] <= '0;
                rd_ptr[n] <= '0;
                cnt[n]    <= '0;
            end else begin
                if (push[n]) begin
                    wr_ptr[n] <= wr_ptr[n] + 1'b1;
                end
                if (pop[n]) begin
                    rd_ptr[n] <= rd_ptr[n] + 1'b1;
                end
                cnt[n] <= cnt[n] + CNT_W'(push[n]) - CNT_W'(pop[n]);
            end
        end
    end

    // FIFO storage; only written on an accepted, non-dropped write
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (push[n]) begin
                mem_addr[n][wr_ptr[n]] <= req_addr[n];
                mem_data[n][wr_ptr[n]] <= req_data[n];
            end
        end
    end

    // Stage p1: register the granted head onto the write port; hold address/data when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            we_p1      <= 1'b0;
            wa_p1      <= '0;
            wd_p1      <= '0;
            last_grant <= 1'b1;
            drop_err_q <= 1'b0;
        end else begin
            we_p1 <= grant_vld;
            if (grant_vld) begin
                wa_p1      <= mem_addr[grant_sel][rd_ptr[grant_sel]];
                wd_p1      <= mem_data[grant_sel][rd_ptr[grant_sel]];
                last_grant <= grant_sel;
            end
            if (|(accept & ~push)) begin
                drop_err_q <= 1'b1;
            end
        end
    end

    // Hazard lookup: any occupied FIFO slot or the write being issued this cycle
    always_comb begin
        logic [PTR_W-1:0] offs;
        hz1  = 1'b0;
        hz2  = 1'b0;
        offs = '0;
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < DEPTH; i++) begin
                offs = PTR_W'(i) - rd_ptr[n];
                if (CNT_W'(offs) < cnt[n]) begin
                    if (mem_addr[n][i] == bus.rd1_addr) hz1 = 1'b1;
                    if (mem_addr[n][i] == bus.rd2_addr) hz2 = 1'b1;
                end
            end
        end
        if (we_p1 && (wa_p1 == bus.rd1_addr)) hz1 = 1'b1;
        if (we_p1 && (wa_p1 == bus.rd2_addr)) hz2 = 1'b1;
        if (bus.rd1_addr == DROP_ADDR) hz1 = 1'b0;
        if (bus.rd2_addr == DROP_ADDR) hz2 = 1'b0;
    end
endmodule

// File: tb/tb_rf_write_sched.sv
// Bench for rf_write_sched: a directed table with hand-derived expectations,
// a back-pressure sequence, and randomized traffic against a queue-based model.
module tb_rf_write_sched;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_write_sched_if bus ();
    rf_write_sched #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        rst;
        logic        v0;
        logic [2:0]  a0;
        logic [14:0] d0;
        logic        v1;
        logic [2:0]  a1;
        logic [14:0] d1;
        logic [2:0]  rd1;
        logic [2:0]  rd2;
        logic        e_we;
        logic [2:0]  e_wa;
        logic [14:0] e_wd;
        logic        e_r0;
        logic        e_r1;
        logic        e_h1;
        logic        e_h2;
        logic        e_drop;
    } vec_t;

    typedef struct {
        logic [2:0]  a;
        logic [14:0] d;
    } wr_t;

    // reference model state
    wr_t         q0[$];
    wr_t         q1[$];
    logic        m_we;
    logic [2:0]  m_wa;
    logic [14:0] m_wd;
    logic        m_drop;
    int          m_last;

    int   checks = 0;
    int   errors = 0;
    wr_t  obs[$];
    bit   rec = 0;
    bit   saw_full = 0;
    vec_t tbl[18];

    function automatic vec_t mk(int rs, int v0, int a0, int d0, int v1, int a1, int d1,
                                int ra, int rb, int we, int wa, int wd, int r0, int r1,
                                int h1, int h2, int dr);
        vec_t v;
        v.rst = rs[0];   v.v0 = v0[0];   v.a0 = a0[2:0];   v.d0 = d0[14:0];
        v.v1 = v1[0];    v.a1 = a1[2:0]; v.d1 = d1[14:0];
        v.rd1 = ra[2:0]; v.rd2 = rb[2:0];
        v.e_we = we[0];  v.e_wa = wa[2:0]; v.e_wd = wd[14:0];
        v.e_r0 = r0[0];  v.e_r1 = r1[0];  v.e_h1 = h1[0]; v.e_h2 = h2[0];
        v.e_drop = dr[0];
        return v;
    endfunction

    task automatic chk(input string tag, input string what, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0h required=%0h", tag, what, act, exp);
        end
    endtask

    function automatic logic model_hazard(input logic [2:0] rd);
        if (rd == 3'd7) return 1'b0;
        if (m_we && m_wa == rd) return 1'b1;
        foreach (q0[i]) if (q0[i].a == rd) return 1'b1;
        foreach (q1[i]) if (q1[i].a == rd) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge(input vec_t v, input bit acc0, input bit acc1);
        wr_t w;
        int  g;
        if (v.rst) begin
            q0.delete();
            q1.delete();
            m_we = 1'b0; m_wa = '0; m_wd = '0; m_drop = 1'b0; m_last = 1;
        end else begin
            g = -1;
            if (q0.size() > 0 && (q1.size() == 0 || m_last == 1)) g = 0;
            else if (q1.size() > 0) g = 1;
            if (g == 0) w = q0.pop_front();
            if (g == 1) w = q1.pop_front();
            if (g >= 0) begin
                m_we = 1'b1; m_wa = w.a; m_wd = w.d; m_last = g;
            end else begin
                m_we = 1'b0;
            end
            if (acc0) begin
                if (v.a0 == 3'd7) m_drop = 1'b1;
                else begin w.a = v.a0; w.d = v.d0; q0.push_back(w); end
            end
            if (acc1) begin
                if (v.a1 == 3'd7) m_drop = 1'b1;
                else begin w.a = v.a1; w.d = v.d1; q1.push_back(w); end
            end
        end
    endtask

    // drive one cycle of inputs, compare outputs (model, optionally table), advance model at the edge
    task automatic step(input vec_t v, input bit use_exp, input string tag);
        bit  acc0;
        bit  acc1;
        wr_t w;
        @(negedge clk);
        rst = v.rst;
        bus.req0_valid = v.v0; bus.req0_addr = v.a0; bus.req0_data = v.d0;
        bus.req1_valid = v.v1; bus.req1_addr = v.a1; bus.req1_data = v.d1;
        bus.rd1_addr = v.rd1;  bus.rd2_addr = v.rd2;
        #1;
        chk(tag, "we",    int'(bus.rf_we),      int'(m_we));
        chk(tag, "wa",    int'(bus.rf_wa),      int'(m_wa));
        chk(tag, "wd",    int'(bus.rf_wd),      int'(m_wd));
        chk(tag, "rdy0",  int'(bus.req0_ready), (!v.rst && q0.size() < DEPTH) ? 1 : 0);
        chk(tag, "rdy1",  int'(bus.req1_ready), (!v.rst && q1.size() < DEPTH) ? 1 : 0);
        chk(tag, "haz1",  int'(bus.hazard1),    int'(model_hazard(v.rd1)));
        chk(tag, "haz2",  int'(bus.hazard2),    int'(model_hazard(v.rd2)));
        chk(tag, "drop",  int'(bus.drop_err),   int'(m_drop));
        if (use_exp) begin
            chk(tag, "tbl_we",   int'(bus.rf_we),      int'(v.e_we));
            chk(tag, "tbl_wa",   int'(bus.rf_wa),      int'(v.e_wa));
            chk(tag, "tbl_wd",   int'(bus.rf_wd),      int'(v.e_wd));
            chk(tag, "tbl_rdy0", int'(bus.req0_ready), int'(v.e_r0));
            chk(tag, "tbl_rdy1", int'(bus.req1_ready), int'(v.e_r1));
            chk(tag, "tbl_haz1", int'(bus.hazard1),    int'(v.e_h1));
            chk(tag, "tbl_haz2", int'(bus.hazard2),    int'(v.e_h2));
            chk(tag, "tbl_drop", int'(bus.drop_err),   int'(v.e_drop));
        end
        if (rec && bus.rf_we) begin
            w.a = bus.rf_wa; w.d = bus.rf_wd; obs.push_back(w);
        end
        if (!v.rst && v.v0 && !bus.req0_ready) saw_full = 1;
        acc0 = !v.rst && v.v0 && (q0.size() < DEPTH);
        acc1 = !v.rst && v.v1 && (q1.size() < DEPTH);
        @(posedge clk);
        model_edge(v, acc0, acc1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_wa[8];
        int exp_wd[8];
        int ai;
        int bi;
        vec_t v;

        //            rst v0 a0 d0       v1 a1 d1       rd1 rd2 | we wa wd      r0 r1 h1 h2 drop
        tbl[0]  = mk(1, 1, 3, 'h1ABC, 0, 0, 0,       3, 0,   0, 0, 0,       0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 3, 'h1ABC, 0, 0, 0,       3, 5,   0, 0, 0,       1, 1, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0,      0, 0, 0,       3, 3,   0, 0, 0,       1, 1, 1, 1, 0);
        tbl[3]  = mk(0, 0, 0, 0,      0, 0, 0,       3, 4,   1, 3, 'h1ABC,  1, 1, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0,      0, 0, 0,       3, 0,   0, 3, 'h1ABC,  1, 1, 0, 0, 0);
        tbl[5]  = mk(1, 0, 0, 0,      0, 0, 0,       3, 0,   0, 3, 'h1ABC,  0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 1, 'h0011, 1, 2, 'h0022,  1, 2,   0, 0, 0,       1, 1, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0,      0, 0, 0,       1, 2,   0, 0, 0,       1, 1, 1, 1, 0);
        tbl[8]  = mk(0, 0, 0, 0,      0, 0, 0,       1, 2,   1, 1, 'h0011,  1, 1, 1, 1, 0);
        tbl[9]  = mk(0, 0, 0, 0,      0, 0, 0,       1, 2,   1, 2, 'h0022,  1, 1, 0, 1, 0);
        tbl[10] = mk(0, 0, 0, 0,      1, 7, 'h7FFF,  7, 2,   0, 2, 'h0022,  1, 1, 0, 0, 0);
        tbl[11] = mk(0, 0, 0, 0,      0, 0, 0,       7, 2,   0, 2, 'h0022,  1, 1, 0, 0, 1);
        tbl[12] = mk(0, 0, 0, 0,      0, 0, 0,       0, 1,   0, 2, 'h0022,  1, 1, 0, 0, 1);
        tbl[13] = mk(0, 1, 4, 'h0044, 1, 5, 'h0055,  4, 5,   0, 2, 'h0022,  1, 1, 0, 0, 1);
        tbl[14] = mk(0, 1, 6, 'h0066, 0, 0, 0,       6, 5,   0, 2, 'h0022,  1, 1, 0, 1, 1);
        tbl[15] = mk(1, 1, 1, 'h0101, 0, 0, 0,       6, 4,   1, 4, 'h0044,  0, 0, 1, 1, 1);
        tbl[16] = mk(0, 0, 0, 0,      0, 0, 0,       6, 5,   0, 0, 0,       1, 1, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 0,      0, 0, 0,       1, 5,   0, 0, 0,       1, 1, 0, 0, 0);

        exp_wa = '{1, 6, 2, 6, 3, 6, 4, 6};
        exp_wd = '{'h0A1, 'h100, 'h0A2, 'h101, 'h0A3, 'h102, 'h0A4, 'h103};

        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
        bus.rd1_addr = '0; bus.rd2_addr = '0;
        repeat (2) @(posedge clk);
        model_edge(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);

        // directed table: latency, tie after reset, drop, reset mid-operation
        for (int i = 0; i < 18; i++) begin
            step(tbl[i], 1'b1, $sformatf("tbl%0d", i));
        end

        // back-pressure: req0 pushes 4 writes while req1 streams, DEPTH=2
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "bp_rst");
        rec = 1;
        saw_full = 0;
        ai = 0;
        bi = 0;
        for (int c = 0; c < 30; c++) begin
            v = mk(0, (ai < 4) ? 1 : 0, ai + 1, 'h0A1 + ai, (bi < 6) ? 1 : 0, 6, 'h100 + bi,
                   ai + 1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
            if (v.v0 && q0.size() < DEPTH) ai++;
            if (v.v1 && q1.size() < DEPTH) bi++;
            step(v, 1'b0, "bp");
        end
        rec = 0;
        chk("bp", "req0_full_seen", saw_full ? 1 : 0, 1);
        chk("bp", "write_count_ge8", (obs.size() >= 8) ? 1 : 0, 1);
        for (int i = 0; i < 8; i++) begin
            if (i < obs.size()) begin
                chk($sformatf("bp%0d", i), "wa", int'(obs[i].a), exp_wa[i]);
                chk($sformatf("bp%0d", i), "wd", int'(obs[i].d), exp_wd[i]);
            end
        end

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            v = mk(($urandom_range(0, 59) == 0) ? 1 : 0,
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 32767)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 32767)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   0, 0, 0, 0, 0, 0, 0, 0);
            step(v, 1'b0, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
